// File: rtl/flag_branch_unit_pkg.sv
// Shared definitions for the NZCV flag register and branch-decision logic.
// cond_eval is kept here so the future pipeline hazard unit can reuse it.
package flag_pkg;

    localparam int unsigned COND_W = 4;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_HS = 4'h2;
    localparam logic [3:0] COND_LO = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam logic [1:0] BR_KIND_BCOND = 2'b00;
    localparam logic [1:0] BR_KIND_CBZ   = 2'b01;
    localparam logic [1:0] BR_KIND_CBNZ  = 2'b10;
    localparam logic [1:0] BR_KIND_RSVD  = 2'b11;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } br_state_e;

    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v, taken;
        n = nzcv[FLAG_N];
        z = nzcv[FLAG_Z];
        c = nzcv[FLAG_C];
        v = nzcv[FLAG_V];
        case (cond)
            COND_EQ: taken = z;
            COND_NE: taken = !z;
            COND_HS: taken = c;
            COND_LO: taken = !c;
            COND_MI: taken = n;
            COND_PL: taken = !n;
            COND_VS: taken = v;
            COND_VC: taken = !v;
            COND_HI: taken = c & !z;
            COND_LS: taken = !c | z;
            COND_GE: taken = (n == v);
            COND_LT: taken = (n != v);
            COND_GT: taken = !z & (n == v);
            COND_LE: taken = z | (n != v);
            default: taken = 1'b1;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/flag_branch_unit_if.sv
// ALU-flag / branch-request / fetch-handshake bundle for flag_branch_unit.
// master = ALU and fetch side, slave = the flag/branch unit.
interface flag_branch_unit_if #(parameter int unsigned COND_W = 4);

    logic              alu_valid;
    logic              set_flags;
    logic              alu_negative;
    logic              alu_zero;
    logic              alu_overflow;
    logic              alu_carry_out;
    logic              br_req;
    logic [1:0]        br_kind;
    logic [COND_W-1:0] cond_code;
    logic              br_req_ready;
    logic              br_valid;
    logic              br_taken;
    logic              br_ready;
    logic [3:0]        flags_q;
    logic              flags_known;

    modport master (
        output alu_valid, set_flags, alu_negative, alu_zero, alu_overflow, alu_carry_out,
        output br_req, br_kind, cond_code, br_ready,
        input  br_req_ready, br_valid, br_taken, flags_q, flags_known
    );

    modport slave (
        input  alu_valid, set_flags, alu_negative, alu_zero, alu_overflow, alu_carry_out,
        input  br_req, br_kind, cond_code, br_ready,
        output br_req_ready, br_valid, br_taken, flags_q, flags_known
    );

endinterface

// File: rtl/flag_branch_unit_flag_reg.sv
// Architectural NZCV register with write enable and a sticky "written since reset" bit.
module flag_reg
    import flag_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en_i,
    input  logic [3:0] nzcv_i,
    output logic [3:0] nzcv_o,
    output logic       known_o
);

    logic [3:0] nzcv_q, nzcv_d;
    logic       known_q, known_d;

    always_comb begin
        nzcv_d  = nzcv_q;
        known_d = known_q;
        if (en_i) begin
            nzcv_d  = nzcv_i;
            known_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            nzcv_q  <= '0;
            known_q <= 1'b0;
        end else begin
            nzcv_q  <= nzcv_d;
            known_q <= known_d;
        end
    end

    assign nzcv_o  = nzcv_q;
    assign known_o = known_q;

endmodule

// File: rtl/flag_branch_unit.sv
// NZCV flag register plus B.cond/CBZ/CBNZ evaluation, with a registered
// decision presented to fetch over a valid/ready handshake.
module flag_branch_unit
    import flag_pkg::*;
#(
    parameter int unsigned COND_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    flag_branch_unit_if.slave bus
);

    br_state_e  state_q, state_d;
    logic       taken_q, taken_d;
    logic       flag_we;
    logic [3:0] alu_nzcv;
    logic [3:0] flags_cur;
    logic [3:0] eff_nzcv;
    logic       decision;
    logic       known;

    assign flag_we  = bus.alu_valid & bus.set_flags;
    assign alu_nzcv = {bus.alu_negative, bus.alu_zero, bus.alu_carry_out, bus.alu_overflow};

    flag_reg u_flag_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (flag_we),
        .nzcv_i  (alu_nzcv),
        .nzcv_o  (flags_cur),
        .known_o (known)
    );

    // Same-cycle flag-setting op bypasses the register so B.cond sees its result.
    assign eff_nzcv = flag_we ? alu_nzcv : flags_cur;

    always_comb begin
        decision = 1'b0;
        case (bus.br_kind)
            BR_KIND_BCOND: decision = cond_eval(bus.cond_code[COND_W-1:0], eff_nzcv);
            BR_KIND_CBZ:   decision = bus.alu_valid & bus.alu_zero;
            BR_KIND_CBNZ:  decision = bus.alu_valid & !bus.alu_zero;
            default:       decision = 1'b0;
        endcase
    end

    always_comb begin
        state_d          = state_q;
        taken_d          = taken_q;
        bus.br_req_ready = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                bus.br_req_ready = 1'b1;
                if (bus.br_req) begin
                    taken_d = decision;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.br_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            taken_q <= taken_d;
        end
    end

    assign bus.br_valid    = (state_q == ST_HOLD);
    assign bus.br_taken    = taken_q;
    assign bus.flags_q     = flags_cur;
    assign bus.flags_known = known;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed bench for flag_branch_unit: expected decisions are queued at issue
// and popped when br_valid is seen.
module tb_flag_branch_unit;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;
    logic sb[$];

    flag_branch_unit_if #(.COND_W(4)) bus ();

    flag_branch_unit #(.COND_W(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_alu;
        bus.alu_valid     = 1'b0;
        bus.set_flags     = 1'b0;
        bus.alu_negative  = 1'b0;
        bus.alu_zero      = 1'b0;
        bus.alu_carry_out = 1'b0;
        bus.alu_overflow  = 1'b0;
    endtask

    task automatic set_alu(input logic v, input logic sf, input logic [3:0] nzcv);
        bus.alu_valid     = v;
        bus.set_flags     = sf;
        bus.alu_negative  = nzcv[3];
        bus.alu_zero      = nzcv[2];
        bus.alu_carry_out = nzcv[1];
        bus.alu_overflow  = nzcv[0];
    endtask

    task automatic issue(input logic [1:0] kind, input logic [3:0] cond, input logic exp);
        bus.br_req    = 1'b1;
        bus.br_kind   = kind;
        bus.cond_code = cond;
        sb.push_back(exp);
        tick();
        bus.br_req = 1'b0;
    endtask

    task automatic pop_check(input string tag);
        int n;
        logic e;
        n = 0;
        while (bus.br_valid !== 1'b1 && n < 4) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, {31'b0, bus.br_valid}, 32'd1);
        chk({tag, "_sb_nonempty"}, {31'b0, (sb.size() != 0)}, 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_taken"}, {31'b0, bus.br_taken}, {31'b0, e});
        end
    endtask

    task automatic consume(input string tag);
        bus.br_ready = 1'b1;
        tick();
        bus.br_ready = 1'b0;
        bus.br_req   = 1'b0;
        chk({tag, "_cleared"}, {31'b0, bus.br_valid}, 32'd0);
        chk({tag, "_ready_back"}, {31'b0, bus.br_req_ready}, 32'd1);
    endtask

    initial begin
        logic [15:0] tbl;
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        clear_alu();
        bus.br_req    = 1'b0;
        bus.br_kind   = 2'b00;
        bus.cond_code = 4'h0;
        bus.br_ready  = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        chk("rst_flags", {28'b0, bus.flags_q}, 32'h0);
        chk("rst_valid", {31'b0, bus.br_valid}, 32'd0);
        chk("rst_req_ready", {31'b0, bus.br_req_ready}, 32'd1);
        chk("rst_known", {31'b0, bus.flags_known}, 32'd0);

        // SUBS 1-1 with B.EQ in the same cycle: bypassed flags
        set_alu(1'b1, 1'b1, 4'b0110);
        issue(2'b00, 4'h0, 1'b1);
        clear_alu();
        chk("byp_flags", {28'b0, bus.flags_q}, 32'h6);
        chk("byp_known", {31'b0, bus.flags_known}, 32'd1);
        chk("byp_req_ready", {31'b0, bus.br_req_ready}, 32'd0);
        pop_check("byp_eq");
        consume("byp_eq");

        // SUBS 0x5000..-0xC000..: N1 Z0 C0 V1, then sweep every condition
        set_alu(1'b1, 1'b1, 4'b1001);
        tick();
        clear_alu();
        chk("subs_flags", {28'b0, bus.flags_q}, 32'h9);
        tbl = 16'hD65A;
        for (int i = 0; i < 16; i++) begin
            issue(2'b00, 4'(i), tbl[i]);
            pop_check($sformatf("cond%0d", i));
            consume($sformatf("cond%0d", i));
        end

        // CBZ / CBNZ on PASS_B result, flags untouched
        set_alu(1'b1, 1'b0, 4'b0100);
        issue(2'b01, 4'h0, 1'b1);
        clear_alu();
        pop_check("cbz_z1");
        consume("cbz_z1");
        set_alu(1'b1, 1'b0, 4'b0000);
        issue(2'b10, 4'h0, 1'b1);
        clear_alu();
        pop_check("cbnz_z0");
        consume("cbnz_z0");
        set_alu(1'b0, 1'b0, 4'b0100);
        issue(2'b01, 4'h0, 1'b0);
        clear_alu();
        pop_check("cbz_novalid");
        consume("cbz_novalid");
        set_alu(1'b1, 1'b0, 4'b0100);
        issue(2'b11, 4'hE, 1'b0);
        clear_alu();
        pop_check("rsvd_kind");
        consume("rsvd_kind");
        chk("cb_flags", {28'b0, bus.flags_q}, 32'h9);

        // Backpressure: B.NE held 3 cycles, ADDS and a stray request during the hold
        issue(2'b00, 4'h1, 1'b1);
        pop_check("bp_ne");
        for (int i = 0; i < 3; i++) begin
            if (i == 0) set_alu(1'b1, 1'b1, 4'b0110);
            bus.br_req    = 1'b1;
            bus.br_kind   = 2'b00;
            bus.cond_code = 4'h1;
            tick();
            clear_alu();
            chk($sformatf("bp_valid%0d", i), {31'b0, bus.br_valid}, 32'd1);
            chk($sformatf("bp_taken%0d", i), {31'b0, bus.br_taken}, 32'd1);
            chk($sformatf("bp_req_ready%0d", i), {31'b0, bus.br_req_ready}, 32'd0);
        end
        chk("bp_flags", {28'b0, bus.flags_q}, 32'h6);
        consume("bp_release");

        // Reset while a decision is held
        issue(2'b00, 4'hE, 1'b1);
        pop_check("hold_al");
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("mid_rst_valid", {31'b0, bus.br_valid}, 32'd0);
        chk("mid_rst_taken", {31'b0, bus.br_taken}, 32'd0);
        chk("mid_rst_flags", {28'b0, bus.flags_q}, 32'h0);
        chk("mid_rst_known", {31'b0, bus.flags_known}, 32'd0);
        chk("mid_rst_req_ready", {31'b0, bus.br_req_ready}, 32'd1);
        tick();
        chk("mid_rst_still_idle", {31'b0, bus.br_valid}, 32'd0);
        chk("sb_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
